// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling, stop-bit check and a
// level valid/acknowledge handshake toward the downstream consumer.
//
// state     | meaning
// IDLE      | line idle, waiting for the start bit to begin
// START     | timing to mid start bit, rejecting short glitches
// DATA      | sampling data bits at bit centres, LSB first
// STOP      | sampling stop bit; publish byte or flag a frame error
// WAIT_IDLE | line held low after a bad stop, wait for it to return high
module uart_rx #(
  parameter int CLK_FREQ      = 100000000,
  parameter int BAUD_RATE     = 115200,
  parameter int RX_DATA_WIDTH = 8
) (
  input  logic                     CLK_100MHz_in,
  input  logic                     rst_n_in,
  input  logic                     uart_rx_in,
  input  logic                     uart_received_in,
  output logic                     uart_receive_reg_out,
  output logic [RX_DATA_WIDTH-1:0] uart_rxdata_reg_out,
  output logic                     uart_frame_error_reg_out,
  output logic                     uart_overrun_reg_out
);

  localparam int CPB   = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB);
  localparam int IDX_W = $clog2(RX_DATA_WIDTH) + 1;

  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(RX_DATA_WIDTH - 1);

  if (CPB < 4) begin : g_bad_cpb
    $error("uart_rx: clocks per bit (%0d) must be at least 4", CPB);
  end

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t                   state, state_nxt;
  logic                     rx_meta, rx_s;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic [IDX_W-1:0]         idx, idx_nxt;
  logic [RX_DATA_WIDTH-1:0] shift, shift_nxt;
  logic [RX_DATA_WIDTH-1:0] data_nxt;
  logic                     valid_nxt, ferr_nxt, ovr_nxt;

  always_ff @(posedge CLK_100MHz_in) begin
    if (!rst_n_in) begin
      rx_meta                  <= 1'b1;
      rx_s                     <= 1'b1;
      state                    <= IDLE;
      cnt                      <= '0;
      idx                      <= '0;
      shift                    <= '0;
      uart_receive_reg_out     <= 1'b0;
      uart_rxdata_reg_out      <= '0;
      uart_frame_error_reg_out <= 1'b0;
      uart_overrun_reg_out     <= 1'b0;
    end else begin
      rx_meta                  <= uart_rx_in;
      rx_s                     <= rx_meta;
      state                    <= state_nxt;
      cnt                      <= cnt_nxt;
      idx                      <= idx_nxt;
      shift                    <= shift_nxt;
      uart_receive_reg_out     <= valid_nxt;
      uart_rxdata_reg_out      <= data_nxt;
      uart_frame_error_reg_out <= ferr_nxt;
      uart_overrun_reg_out     <= ovr_nxt;
    end
  end

  // Bit timers count down from a load value; each sample happens at terminal count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shift_nxt = shift;
    data_nxt  = uart_rxdata_reg_out;
    valid_nxt = uart_receive_reg_out && !uart_received_in;
    ferr_nxt  = 1'b0;
    ovr_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_nxt   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt == '0) begin
          if (!rx_s) begin
            state_nxt = DATA;
            cnt_nxt   = BIT_LOAD;
            idx_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shift_nxt = {rx_s, shift[RX_DATA_WIDTH-1:1]};
          cnt_nxt   = BIT_LOAD;
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = STOP;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (rx_s) begin
            // A completing byte beats a same-edge acknowledge; unacked data is overwritten.
            data_nxt  = shift;
            valid_nxt = 1'b1;
            ovr_nxt   = uart_receive_reg_out && !uart_received_in;
            state_nxt = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
